// File: rtl/inst_decoder.sv
// Instruction decoder: buffers 28-bit instructions in a small FIFO and turns each one
// into a burst of memory beat strobes or a compute dispatch that waits for op_done.
module inst_decoder #(
    parameter int INST_WIDTH = 28,
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_port,
    output logic                  mem_last,
    output logic                  op_start,
    output logic [2:0]            op_code,
    output logic [3:0]            op_a,
    output logic [3:0]            op_b,
    output logic [3:0]            op_c,
    output logic [1:0]            op_mode,
    input  logic                  op_done,
    output logic                  illegal,
    output logic                  busy,
    output logic [15:0]           retired,
    output logic [1:0]            dbg_state
);

    // Handshake: a word transfers on any posedge where inst_valid && inst_ready;
    // inst_ready depends only on the registered FIFO count, never on inst_valid.

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM      = 2'd1,
        OP_ISSUE = 2'd2,
        OP_WAIT  = 2'd3
    } state_t;

    state_t state;

    logic [INST_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  push;
    logic                  pop;

    logic [INST_WIDTH-1:0] head;
    logic [2:0]            head_op;
    logic                  head_is_mem;
    logic                  head_is_cmp;
    logic [5:0]            head_len;

    logic [5:0]            len_r;
    logic [5:0]            beat;

    assign push = inst_valid && inst_ready;
    assign pop  = (state == IDLE) && (count != '0);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    assign head        = fifo_mem[rd_ptr];
    assign head_op     = head[27:25];
    assign head_len    = head[12:7];
    assign head_is_mem = (head_op == 3'b000);
    assign head_is_cmp = (head_op == 3'b100) || (head_op == 3'b101) || (head_op == 3'b110);
    assign dbg_state   = state;

    // Storage needs no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= inst;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            inst_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_nxt;
            inst_ready <= (count_nxt != FULL_CNT);
        end
    end

    // Outputs are computed one edge ahead so each is registered in the cycle it applies to.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            len_r    <= '0;
            beat     <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            mem_port <= '0;
            mem_last <= 1'b0;
            op_start <= 1'b0;
            op_code  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_c     <= '0;
            op_mode  <= '0;
            illegal  <= 1'b0;
            busy     <= 1'b0;
            retired  <= '0;
        end else begin
            op_start <= 1'b0;
            illegal  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_is_mem) begin
                            state    <= MEM;
                            len_r    <= head_len;
                            beat     <= '0;
                            mem_en   <= (head_len != 6'd0);
                            mem_addr <= head[24:13];
                            mem_port <= head[6:5];
                            mem_last <= (head_len == 6'd1);
                            busy     <= 1'b1;
                        end else if (head_is_cmp) begin
                            state    <= OP_ISSUE;
                            op_start <= 1'b1;
                            op_code  <= head_op;
                            op_a     <= head[24:21];
                            op_b     <= head[20:17];
                            op_c     <= head[16:13];
                            op_mode  <= head[12:11];
                            busy     <= 1'b1;
                        end else begin
                            illegal  <= 1'b1;
                            retired  <= retired + 16'd1;
                            busy     <= (count_nxt != '0);
                        end
                    end else begin
                        busy <= (count_nxt != '0);
                    end
                end
                MEM: begin
                    // A zero-length burst spends one cycle here and retires with no beats.
                    if ((len_r == 6'd0) || (beat == len_r - 6'd1)) begin
                        state    <= IDLE;
                        mem_en   <= 1'b0;
                        mem_last <= 1'b0;
                        retired  <= retired + 16'd1;
                        busy     <= (count_nxt != '0);
                    end else begin
                        beat     <= beat + 6'd1;
                        mem_addr <= mem_addr + ADDR_WIDTH'(1);
                        mem_last <= (beat + 6'd2 == len_r);
                        busy     <= 1'b1;
                    end
                end
                OP_ISSUE: begin
                    state <= OP_WAIT;
                    busy  <= 1'b1;
                end
                OP_WAIT: begin
                    if (op_done) begin
                        state   <= IDLE;
                        retired <= retired + 16'd1;
                        busy    <= (count_nxt != '0);
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= (count_nxt != '0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_decoder.sv
// Bench for inst_decoder: directed scenarios plus random traffic, with expected
// output events queued at acceptance time and popped by an independent monitor.
module tb_inst_decoder;

    localparam int EW = 19;

    logic        clk;
    logic        rstn;
    logic [27:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        mem_en;
    logic [11:0] mem_addr;
    logic [1:0]  mem_port;
    logic        mem_last;
    logic        op_start;
    logic [2:0]  op_code;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic [3:0]  op_c;
    logic [1:0]  op_mode;
    logic        op_done;
    logic        illegal;
    logic        busy;
    logic [15:0] retired;
    logic [1:0]  dbg_state;

    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int exp_retired = 0;
    int beat_seen = 0;
    int fixed_delay = -1;
    int stray_req = 0;
    int stray_ack = 0;
    bit saw_full = 0;

    inst_decoder #(.INST_WIDTH(28), .ADDR_WIDTH(12), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rstn(rstn), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_port(mem_port), .mem_last(mem_last), .op_start(op_start),
        .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_c(op_c),
        .op_mode(op_mode), .op_done(op_done), .illegal(illegal), .busy(busy),
        .retired(retired), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got still running, expected finished");
        $fatal(1, "watchdog");
    end

    // expected-event encoding
    function automatic logic [EW-1:0] ev_mem(input int port, input bit last, input int addr);
        return {2'd1, 2'd0, 2'(port), last, 12'(addr)};
    endfunction

    function automatic logic [EW-1:0] ev_op(input int code, input int a, input int b, input int c, input int mode);
        return {2'd2, 3'(code), 4'(a), 4'(b), 4'(c), 2'(mode)};
    endfunction

    function automatic logic [EW-1:0] ev_ill();
        return {2'd3, 17'd0};
    endfunction

    // reference model: what one accepted instruction must produce
    task automatic model_accept(input logic [27:0] w);
        int word;
        int opc;
        int addr;
        int len;
        int port;
        word = int'(w);
        opc = word / (1 << 25);
        exp_retired++;
        if (opc == 0) begin
            addr = (word / (1 << 13)) % 4096;
            len  = (word / (1 << 7)) % 64;
            port = (word / (1 << 5)) % 4;
            for (int k = 0; k < len; k++) begin
                exp_q.push_back(ev_mem(port, k == len - 1, (addr + k) % 4096));
            end
        end else if (opc >= 4 && opc <= 6) begin
            exp_q.push_back(ev_op(opc, (word / (1 << 21)) % 16, (word / (1 << 17)) % 16,
                                  (word / (1 << 13)) % 16, (word / (1 << 11)) % 4));
        end else begin
            exp_q.push_back(ev_ill());
        end
    endtask

    function automatic logic [27:0] mk_mem(input int addr, input int len, input int port);
        logic [4:0] junk;
        junk = 5'($urandom);
        return {3'b000, 12'(addr), 6'(len), 2'(port), junk};
    endfunction

    function automatic logic [27:0] mk_cmp(input int code, input int a, input int b, input int c, input int mode);
        logic [10:0] junk;
        junk = 11'($urandom);
        return {3'(code), 4'(a), 4'(b), 4'(c), 2'(mode), junk};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // driver tasks (always entered at a negedge)
    task automatic push_inst(input logic [27:0] w);
        int waited = 0;
        inst = w;
        inst_valid = 1'b1;
        while (!inst_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!inst_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got inst_ready=0 for %0d cycles, expected 1", waited);
            inst_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(w);
        @(negedge clk);
        inst_valid = 1'b0;
        if (!inst_ready) saw_full = 1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(n >= 3000), 0);
    endtask

    // scoreboard monitor
    task automatic compare_event(input string name, input logic [EW-1:0] obs);
        logic [EW-1:0] e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got unexpected event %h, expected none", name, obs);
        end else begin
            e = exp_q.pop_front();
            if (e !== obs) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", name, obs, e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mem_en) begin
                beat_seen++;
                compare_event("mem_beat", {2'd1, 2'd0, mem_port, mem_last, mem_addr});
            end
            if (op_start) compare_event("op_start", {2'd2, op_code, op_a, op_b, op_c, op_mode});
            if (illegal) compare_event("illegal", {2'd3, 17'd0});
        end
    end

    // compute-unit responder
    initial begin
        int d;
        bit spur;
        op_done = 1'b0;
        forever begin
            @(negedge clk);
            op_done = 1'b0;
            if (stray_req != stray_ack) begin
                op_done = 1'b1;
                stray_ack++;
            end else if (rstn && op_start) begin
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 6));
                spur = (fixed_delay < 0) && ($urandom_range(0, 1) == 1);
                if (spur) op_done = 1'b1;
                @(negedge clk);
                op_done = 1'b0;
                repeat (d) @(negedge clk);
                op_done = 1'b1;
            end
        end
    end

    // stimulus
    initial begin
        int n;
        int b0;
        int r;
        int snap;
        rstn = 1'b0;
        inst = '0;
        inst_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_inst_ready", int'(inst_ready), 1);
        check("rst_mem_en", int'(mem_en), 0);
        check("rst_op_start", int'(op_start), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // basic burst with latency check
        push_inst(mk_mem(100, 4, 0));
        check("lat_not_yet", int'(mem_en), 0);
        @(negedge clk);
        check("lat_first_beat", int'(mem_en), 1);
        check("lat_first_addr", int'(mem_addr), 100);
        drain("drain_basic");
        check("basic_retired", int'(retired), 1);
        check("basic_busy", int'(busy), 0);

        // address wrap
        push_inst(mk_mem(4094, 4, 2));
        drain("drain_wrap");
        check("wrap_retired", int'(retired), 2);

        // zero length followed by a normal burst
        push_inst(mk_mem(50, 0, 1));
        push_inst(mk_mem(60, 2, 3));
        drain("drain_len0");
        check("len0_retired", int'(retired), 4);

        // compute with a long wait
        fixed_delay = 20;
        push_inst(mk_cmp(4, 1, 2, 3, 0));
        repeat (12) @(negedge clk);
        check("wait_busy", int'(busy), 1);
        check("wait_retired", int'(retired), 4);
        drain("drain_cmp");
        check("cmp_retired", int'(retired), 5);
        fixed_delay = -1;

        // stray op_done while idle
        stray_req++;
        repeat (4) @(negedge clk);
        check("stray_retired", int'(retired), 5);
        check("stray_busy", int'(busy), 0);

        // fill the FIFO
        saw_full = 0;
        for (int i = 0; i < 6; i++) push_inst(mk_mem(int'($urandom_range(0, 4095)), 2, i % 4));
        check("fifo_full_seen", int'(saw_full), 1);
        drain("drain_fill");
        check("fill_retired", int'(retired), 11);

        // illegal opcode
        push_inst({3'b011, 25'($urandom)});
        drain("drain_illegal");
        check("illegal_retired", int'(retired), 12);

        // reset during beat 2 of an 8-beat burst, with more work queued
        b0 = beat_seen;
        push_inst(mk_mem(200, 8, 1));
        push_inst(mk_mem(300, 3, 0));
        push_inst(mk_mem(400, 3, 2));
        #2;
        n = 0;
        while (beat_seen - b0 < 3 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("midreset_reach_beat2", int'(n >= 100), 0);
        rstn = 1'b0;
        exp_q.delete();
        exp_retired = 0;
        #1;
        check("midreset_mem_en", int'(mem_en), 0);
        check("midreset_mem_last", int'(mem_last), 0);
        check("midreset_inst_ready", int'(inst_ready), 1);
        check("midreset_busy", int'(busy), 0);
        check("midreset_retired", int'(retired), 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("postreset_busy", int'(busy), 0);
        check("postreset_retired", int'(retired), 0);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                push_inst(mk_mem(int'($urandom_range(0, 4095)), int'($urandom_range(0, 10)),
                                 int'($urandom_range(0, 3))));
            end else if (r < 8) begin
                push_inst(mk_cmp(int'($urandom_range(4, 6)), int'($urandom_range(0, 15)),
                                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                 int'($urandom_range(0, 3))));
            end else begin
                snap = int'($urandom_range(0, 3));
                push_inst({(snap == 0) ? 3'b001 : (snap == 1) ? 3'b010 : (snap == 2) ? 3'b011 : 3'b111,
                           25'($urandom)});
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("drain_random");
        check("random_retired", int'(retired), exp_retired % 65536);
        check("random_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
